// File: rtl/alu_seq_pkg.sv
// Shared opcode map, FSM state type and opcode classification for alu_seq_nbit.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b1000;
  localparam logic [3:0] OP_SHR = 4'b1001;
  localparam logic [3:0] OP_ROL = 4'b1010;
  localparam logic [3:0] OP_ROR = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1110;
  localparam logic [3:0] OP_DIV = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL    = 2'd1,
    DIV    = 2'd2,
    FINISH = 2'd3
  } state_t;

  function automatic logic is_iterative(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_seq_nbit_if.sv
// Request/response bundle between a requester and the alu_seq_nbit coprocessor.
interface alu_seq_nbit_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry_out;
  logic             zero;
  logic             err;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, opcode,
    input  result, result_hi, carry_out, zero, err, busy, done
  );

  modport slave (
    input  start, A, B, opcode,
    output result, result_hi, carry_out, zero, err, busy, done
  );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative engine: shift-add multiply and restoring divide sharing one 2*WIDTH
// accumulator. Exposes the accumulator's next value so the caller can capture the final step.
module alu_seq_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             div_mode,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_hi_next,
  output logic [WIDTH-1:0] acc_lo_next,
  output logic             last
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   operand_reg;
  logic               div_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;

  // Multiply: {hi,lo} starts as {0,B}; each step adds A into hi when lo[0] is set, then shifts right.
  assign mul_sum = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc_reg[0] ? operand_reg : {WIDTH{1'b0}})};

  // Divide: {rem,quo} starts as {0,A}; the shifted remainder needs WIDTH+1 bits before the trial subtract.
  assign div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, operand_reg};

  always_comb begin
    acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
    if (div_reg) begin
      if (!div_diff[WIDTH]) begin
        acc_next = {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign acc_hi_next = acc_next[2*WIDTH-1:WIDTH];
  assign acc_lo_next = acc_next[WIDTH-1:0];
  assign last        = (cnt_reg == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg     <= '0;
      operand_reg <= '0;
      div_reg     <= 1'b0;
      cnt_reg     <= '0;
    end else if (load) begin
      acc_reg     <= div_mode ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
      operand_reg <= div_mode ? b : a;
      div_reg     <= div_mode;
      cnt_reg     <= '0;
    end else if (step) begin
      acc_reg <= acc_next;
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end
endmodule

// File: rtl/alu_seq_nbit.sv
// WIDTH-bit multi-cycle ALU: single-cycle ops register on the accept edge,
// mul/div run WIDTH iterations in alu_seq_muldiv before the outputs load.
module alu_seq_nbit
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  alu_seq_nbit_if.slave bus
);
  state_t           state_reg;
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] result_hi_reg;
  logic             carry_reg;
  logic             zero_reg;
  logic             err_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [WIDTH-1:0] sc_result;
  logic [WIDTH-1:0] sc_hi;
  logic             sc_carry;
  logic             sc_err;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;

  logic             accept;
  logic             div_by_zero;
  logic             go_iter;
  logic             eng_step;
  logic [WIDTH-1:0] eng_hi;
  logic [WIDTH-1:0] eng_lo;
  logic             eng_last;

  assign add_full = {1'b0, bus.A} + {1'b0, bus.B};
  assign sub_full = {1'b0, bus.A} - {1'b0, bus.B};

  always_comb begin
    sc_result = '0;
    sc_hi     = '0;
    sc_carry  = 1'b0;
    sc_err    = 1'b0;
    case (bus.opcode)
      OP_ADD: {sc_carry, sc_result} = add_full;
      OP_SUB: {sc_carry, sc_result} = sub_full;
      OP_AND: sc_result = bus.A & bus.B;
      OP_OR:  sc_result = bus.A | bus.B;
      OP_XOR: sc_result = bus.A ^ bus.B;
      OP_SHL: {sc_carry, sc_result} = {bus.A, 1'b0};
      OP_SHR: {sc_result, sc_carry} = {1'b0, bus.A};
      OP_ROL: sc_result = {bus.A[WIDTH-2:0], bus.A[WIDTH-1]};
      OP_ROR: sc_result = {bus.A[0], bus.A[WIDTH-1:1]};
      OP_MUL: sc_result = '0;
      // Only reached with B==0; a non-zero divisor takes the iterative path.
      OP_DIV: begin
        sc_result = '1;
        sc_hi     = bus.A;
        sc_err    = 1'b1;
      end
      default: sc_err = 1'b1;
    endcase
  end

  assign accept      = bus.start && !busy_reg;
  assign div_by_zero = (bus.opcode == OP_DIV) && (bus.B == '0);
  assign go_iter     = is_iterative(bus.opcode) && !div_by_zero;
  assign eng_step    = (state_reg == MUL) || (state_reg == DIV);

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk         (clk),
    .rst         (rst),
    .load        (accept && go_iter),
    .div_mode    (bus.opcode == OP_DIV),
    .step        (eng_step),
    .a           (bus.A),
    .b           (bus.B),
    .acc_hi_next (eng_hi),
    .acc_lo_next (eng_lo),
    .last        (eng_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      result_reg    <= '0;
      result_hi_reg <= '0;
      carry_reg     <= 1'b0;
      zero_reg      <= 1'b0;
      err_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        // FINISH is the done cycle; busy is low so a new request is taken as in IDLE.
        IDLE, FINISH: begin
          state_reg <= IDLE;
          if (accept) begin
            if (go_iter) begin
              state_reg <= (bus.opcode == OP_DIV) ? DIV : MUL;
              busy_reg  <= 1'b1;
            end else begin
              state_reg     <= FINISH;
              result_reg    <= sc_result;
              result_hi_reg <= sc_hi;
              carry_reg     <= sc_carry;
              zero_reg      <= (sc_result == '0);
              err_reg       <= sc_err;
              done_reg      <= 1'b1;
            end
          end
        end
        MUL, DIV: begin
          if (eng_last) begin
            state_reg     <= FINISH;
            result_reg    <= eng_lo;
            result_hi_reg <= eng_hi;
            carry_reg     <= (state_reg == MUL) && (eng_hi != '0);
            zero_reg      <= (eng_lo == '0);
            err_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.result    = result_reg;
  assign bus.result_hi = result_hi_reg;
  assign bus.carry_out = carry_reg;
  assign bus.zero      = zero_reg;
  assign bus.err       = err_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
endmodule

// File: tb/tb_alu_seq_nbit.sv
// Directed bench for alu_seq_nbit at WIDTH=8: vector table plus handshake and reset sequences.
module tb_alu_seq_nbit;
  import alu_seq_pkg::*;

  localparam int W = 8;
  localparam int BUDGET = 40;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alu_seq_nbit_if #(.WIDTH(W)) bus ();

  alu_seq_nbit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lat = edges after the accept edge at which outputs load (0 single-cycle, W for mul/div).
  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] res;
    logic [7:0] hi;
    logic       c;
    logic       z;
    logic       e;
    int         lat;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input string name, input logic [7:0] a, input logic [7:0] b,
                              input logic [3:0] op, input logic [7:0] res, input logic [7:0] hi,
                              input logic c, input logic z, input logic e, input int lat);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.op = op; v.res = res; v.hi = hi;
    v.c = c; v.z = z; v.e = e; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, {bus.result, bus.result_hi, bus.carry_out, bus.zero, bus.err, bus.busy, bus.done}, 64'd0);
  endtask

  // Issue one op, scramble the inputs after acceptance, optionally fire an intruding start.
  task automatic run_op(input vec_t v, input bit intrude);
    int  off;
    bit  seen;
    @(negedge clk);
    bus.start = 1'b1; bus.A = v.a; bus.B = v.b; bus.opcode = v.op;
    @(posedge clk);
    seen = 1'b0;
    off  = 0;
    while (!seen && off < BUDGET) begin
      @(negedge clk);
      bus.start = 1'b0; bus.A = ~v.a; bus.B = ~v.b; bus.opcode = OP_ADD;
      if (intrude && off == 2) begin
        bus.start = 1'b1; bus.A = 8'h55; bus.B = 8'h33;
      end
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        check({v.name, ".busy_wait"}, bus.busy, (v.lat > 0));
        off++;
      end
    end
    check({v.name, ".done_seen"}, seen, 1'b1);
    check({v.name, ".latency"}, off, v.lat);
    check({v.name, ".result"}, bus.result, v.res);
    check({v.name, ".result_hi"}, bus.result_hi, v.hi);
    check({v.name, ".flags_cze"}, {bus.carry_out, bus.zero, bus.err}, {v.c, v.z, v.e});
    check({v.name, ".busy_at_done"}, bus.busy, 1'b0);
    $display("op %-10s A=%02h B=%02h opc=%04b -> res=%02h hi=%02h c=%0d z=%0d e=%0d lat=%0d",
             v.name, v.a, v.b, v.op, bus.result, bus.result_hi, bus.carry_out, bus.zero, bus.err, off);
    bus.start = 1'b0;
  endtask

  initial begin
    bit saw_done;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.opcode = OP_ADD;

    vecs[0]  = mk("add_ff_01", 8'hFF, 8'h01, OP_ADD, 8'h00, 8'h00, 1, 1, 0, 0);
    vecs[1]  = mk("and",       8'h2A, 8'h4C, OP_AND, 8'h08, 8'h00, 0, 0, 0, 0);
    vecs[2]  = mk("or",        8'h2A, 8'h4C, OP_OR,  8'h6E, 8'h00, 0, 0, 0, 0);
    vecs[3]  = mk("xor",       8'h2A, 8'h4C, OP_XOR, 8'h66, 8'h00, 0, 0, 0, 0);
    vecs[4]  = mk("rol_81",    8'h81, 8'h00, OP_ROL, 8'h03, 8'h00, 0, 0, 0, 0);
    vecs[5]  = mk("shl_81",    8'h81, 8'h00, OP_SHL, 8'h02, 8'h00, 1, 0, 0, 0);
    vecs[6]  = mk("shr_81",    8'h81, 8'h00, OP_SHR, 8'h40, 8'h00, 1, 0, 0, 0);
    vecs[7]  = mk("ror_81",    8'h81, 8'h00, OP_ROR, 8'hC0, 8'h00, 0, 0, 0, 0);
    vecs[8]  = mk("sub_0f_10", 8'h0F, 8'h10, OP_SUB, 8'hFF, 8'h00, 1, 0, 0, 0);
    vecs[9]  = mk("mul_0f_11", 8'h0F, 8'h11, OP_MUL, 8'hFF, 8'h00, 0, 0, 0, W);
    vecs[10] = mk("mul_80_04", 8'h80, 8'h04, OP_MUL, 8'h00, 8'h02, 1, 1, 0, W);
    vecs[11] = mk("div_64_07", 8'h64, 8'h07, OP_DIV, 8'h0E, 8'h02, 0, 0, 0, W);
    vecs[12] = mk("div_by_0",  8'h2A, 8'h00, OP_DIV, 8'hFF, 8'h2A, 0, 0, 1, 0);
    vecs[13] = mk("illegal",   8'h12, 8'h34, 4'b0101, 8'h00, 8'h00, 0, 1, 1, 0);
    vecs[14] = mk("add_03_04", 8'h03, 8'h04, OP_ADD, 8'h07, 8'h00, 0, 0, 0, 0);

    #6;
    check_all_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i], 1'b0);
    end

    // Asynchronous reset between edges clears outputs without waiting for a clock.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset_midclock");
    $display("seq async_reset: outputs cleared at t=%0t", $time);
    @(negedge clk);
    rst = 1'b0;

    run_op(mk("mul_intrude", 8'h0F, 8'h11, OP_MUL, 8'hFF, 8'h00, 0, 0, 0, W), 1'b1);

    // start held through the done cycle: second op accepted immediately.
    @(negedge clk);
    bus.start = 1'b1; bus.A = 8'h01; bus.B = 8'h02; bus.opcode = OP_ADD;
    @(negedge clk);
    check("b2b.first_done", bus.done, 1'b1);
    check("b2b.first_result", bus.result, 8'h03);
    bus.A = 8'h0F; bus.B = 8'hF0; bus.opcode = OP_XOR;
    @(negedge clk);
    check("b2b.second_done", bus.done, 1'b1);
    check("b2b.second_result", {bus.result, bus.carry_out, bus.err}, {8'hFF, 1'b0, 1'b0});
    bus.start = 1'b0;
    @(negedge clk);
    check("b2b.done_drops", bus.done, 1'b0);
    check("b2b.result_holds", bus.result, 8'hFF);
    $display("seq back_to_back: result=%02h done=%0d", bus.result, bus.done);

    // Reset four cycles into a divide: aborted, no done afterwards.
    @(negedge clk);
    bus.start = 1'b1; bus.A = 8'h64; bus.B = 8'h07; bus.opcode = OP_DIV;
    @(posedge clk);
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      saw_done |= bus.done;
    end
    check("div_abort.busy_before_reset", bus.busy, 1'b1);
    #2 rst = 1'b1;
    #1 check_all_zero("div_abort.reset_outputs");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      saw_done |= bus.done | bus.busy;
    end
    check("div_abort.no_done", saw_done, 1'b0);
    $display("seq div_abort: saw_done_or_busy=%0d", saw_done);
    run_op(vecs[14], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
